bus_mem_responder: RTL and testbench

- Bus-side memory responder: the responder end of the 64-bit tagged request/response bus that the direct-mapped cache drives as initiator.
- Accepts line-read and line-write requests, stores 64 B lines in an internal array, and returns read data as 8 tagged 64-bit beats.
- Serves as the memory model behind the cache in simulation and as the memory-controller stub in integration.

---
 rtl/bus_mem_responder.sv | 135 +++++++++++++
 tb/tb_bus_mem_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_responder.sv
// Bus-side memory responder: stores 64 B lines and answers tagged line
// read/write requests; reads return 8 tagged beats after READ_LATENCY cycles.
module bus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LOG_MEM_LINES  = 8,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);
    localparam int AW = LOG_MEM_LINES + 3;

    typedef enum logic [1:0] {IDLE, WDATA, RWAIT, RESP} state_t;

    logic [BUS_DATA_WIDTH-1:0] mem [0:(1<<AW)-1];

    state_t                     state, state_nxt;
    logic [2:0]                 beat, beat_nxt;
    logic [3:0]                 lat, lat_nxt;
    logic [LOG_MEM_LINES-1:0]   idx, idx_nxt;
    logic [BUS_TAG_WIDTH-1:0]   tag, tag_nxt;
    logic                       respcyc_nxt;
    logic [BUS_DATA_WIDTH-1:0]  resp_nxt;
    logic [BUS_TAG_WIDTH-1:0]   resptag_nxt;
    logic                       mem_we;
    logic                       unused_addr_bits;

    // Offset bits and address bits above the index are deliberately dropped.
    assign unused_addr_bits = ^{bus_req[BUS_DATA_WIDTH-1:6+LOG_MEM_LINES], bus_req[5:0]};

    assign bus_reqack = bus_reqcyc && reset && (state == IDLE || state == WDATA);

    always_comb begin
        state_nxt   = state;
        beat_nxt    = beat;
        lat_nxt     = lat;
        idx_nxt     = idx;
        tag_nxt     = tag;
        respcyc_nxt = bus_respcyc;
        resp_nxt    = bus_resp;
        resptag_nxt = bus_resptag;
        mem_we      = 1'b0;
        case (state)
            IDLE: begin
                if (bus_reqack) begin
                    idx_nxt  = bus_req[6 +: LOG_MEM_LINES];
                    beat_nxt = 3'd0;
                    if (bus_reqtag[BUS_TAG_WIDTH-1]) begin
                        state_nxt = WDATA;
                    end else begin
                        tag_nxt   = bus_reqtag;
                        lat_nxt   = 4'(READ_LATENCY);
                        state_nxt = RWAIT;
                    end
                end
            end
            WDATA: begin
                if (bus_reqack) begin
                    mem_we   = 1'b1;
                    beat_nxt = beat + 3'd1;
                    if (beat == 3'd7) state_nxt = IDLE;
                end
            end
            RWAIT: begin
                if (lat == 4'd0) begin
                    state_nxt   = RESP;
                    beat_nxt    = 3'd0;
                    respcyc_nxt = 1'b1;
                    resp_nxt    = mem[{idx, 3'd0}];
                    resptag_nxt = tag;
                end else begin
                    lat_nxt = lat - 4'd1;
                end
            end
            RESP: begin
                if (bus_respack) begin
                    if (beat == 3'd7) begin
                        state_nxt   = IDLE;
                        beat_nxt    = 3'd0;
                        respcyc_nxt = 1'b0;
                        resp_nxt    = '0;
                        resptag_nxt = '0;
                    end else begin
                        beat_nxt = beat + 3'd1;
                        resp_nxt = mem[{idx, beat + 3'd1}];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            beat        <= 3'd0;
            lat         <= 4'd0;
            idx         <= '0;
            tag         <= '0;
            bus_respcyc <= 1'b0;
            bus_resp    <= '0;
            bus_resptag <= '0;
        end else begin
            state       <= state_nxt;
            beat        <= beat_nxt;
            lat         <= lat_nxt;
            idx         <= idx_nxt;
            tag         <= tag_nxt;
            bus_respcyc <= respcyc_nxt;
            bus_resp    <= resp_nxt;
            bus_resptag <= resptag_nxt;
        end
    end

    // Storage is never reset so lines survive an aborted transaction.
    always_ff @(posedge clk) begin
        if (mem_we) mem[{idx, beat}] <= bus_req;
    end

    a_respack_needs_respcyc: assert property (@(posedge clk) disable iff (!reset)
        bus_respack |-> bus_respcyc);

    a_req_stable_when_stalled: assert property (@(posedge clk) disable iff (!reset)
        (bus_reqcyc && !bus_reqack) |=> (!bus_reqcyc || ($stable(bus_req) && $stable(bus_reqtag))));

endmodule

// File: tb/tb_bus_mem_responder.sv
// Randomized scoreboard bench for bus_mem_responder: stimulus pushes expected
// beats, a negedge monitor drives respack and checks presented beats.
module tb_bus_mem_responder;
    localparam int RL = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bus_reqcyc = 1'b0;
    logic [63:0] bus_req = '0;
    logic [12:0] bus_reqtag = '0;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        bus_respack = 1'b0;

    bus_mem_responder #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .LOG_MEM_LINES(8),
                        .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset), .bus_reqcyc(bus_reqcyc), .bus_req(bus_req),
        .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack));

    always #5 clk = ~clk;

    typedef struct {logic [63:0] data; logic [12:0] tag;} exp_t;
    exp_t        exp_q[$];
    logic [63:0] ref_mem [int];
    logic [63:0] wdata [8];
    int          lines[$];
    int checks = 0, errors = 0;
    int cyc = 0;
    int exp_first = 0;
    bit first_pending = 0;
    int mon_beat = 0;
    int bp_beat = -1, bp_len = 0, bp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every presented beat, pops on the cycle it acks.
    always @(negedge clk) begin
        if (reset && bus_respcyc) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got %h/%h, none expected", bus_resp, bus_resptag);
                bus_respack = 1'b1;
            end else begin
                if (bus_resp !== exp_q[0].data || bus_resptag !== exp_q[0].tag) begin
                    errors++;
                    $display("FAIL resp_beat%0d: got %h/%h want %h/%h", mon_beat,
                             bus_resp, bus_resptag, exp_q[0].data, exp_q[0].tag);
                end
                if (mon_beat == 0 && first_pending) begin
                    first_pending = 0;
                    checks++;
                    if (cyc != exp_first) begin
                        errors++;
                        $display("FAIL read_latency: first beat at edge %0d want %0d", cyc, exp_first);
                    end
                end
                if (mon_beat == bp_beat && bp_cnt < bp_len) begin
                    bus_respack = 1'b0;
                    bp_cnt++;
                end else begin
                    bus_respack = ($urandom_range(0, 3) != 0);
                    if (bus_respack) begin
                        void'(exp_q.pop_front());
                        mon_beat = (mon_beat + 1) % 8;
                        if (mon_beat == 0) bp_beat = -1;
                    end
                end
            end
        end else begin
            bus_respack = 1'b0;
        end
    end

    function automatic int line_of(input logic [63:0] addr);
        return int'((addr >> 6) % 256);
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic [12:0] t, output int edge_no);
        bit ok = 0;
        bus_reqcyc = 1'b1;
        bus_req    = d;
        bus_reqtag = t;
        edge_no    = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus_reqack) begin
                checks++;
                if (bus_respcyc) begin
                    errors++;
                    $display("FAIL ack_while_resp: reqack=1 with respcyc=1");
                end
                edge_no = cyc + 1;
                ok = 1;
                @(posedge clk);
                #1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: beat %h tag %h never acked", d, t);
        end
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [12:0] t, input int gap_after);
        int e;
        int ln = line_of(addr);
        send_beat(addr, t, e);
        for (int k = 0; k < 8; k++) begin
            ref_mem[ln*8 + k] = wdata[k];
            send_beat(wdata[k], t, e);
            if (k == gap_after) begin
                bus_reqcyc = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end
        end
        bus_reqcyc = 1'b0;
        lines.push_back(ln);
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [12:0] t);
        int e;
        int ln = line_of(addr);
        send_beat(addr, t, e);
        bus_reqcyc    = 1'b0;
        exp_first     = e + RL + 1;
        first_pending = 1;
        for (int k = 0; k < 8; k++) exp_q.push_back('{ref_mem[ln*8 + k], {1'b0, t[11:0]}});
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 500 && exp_q.size() != 0; n++) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding", exp_q.size());
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (bus_reqack !== 1'b0 || bus_respcyc !== 1'b0 || bus_resp !== 64'd0 || bus_resptag !== 13'd0) begin
            errors++;
            $display("FAIL %s: ack=%b respcyc=%b resp=%h tag=%h, want all 0", name,
                     bus_reqack, bus_respcyc, bus_resp, bus_resptag);
        end
    endtask

    initial begin
        logic [63:0] a;
        bus_reqcyc = 1'b1;
        bus_req    = 64'h1C0;
        repeat (3) begin
            @(negedge clk);
            check_idle_outputs("reset_outputs");
        end
        reset = 1'b1;
        bus_reqcyc = 1'b0;
        @(posedge clk);
        #1;

        // Directed write/read of line 7
        for (int k = 0; k < 8; k++) wdata[k] = 64'h1111_0000_0000_0000 | 64'(k);
        do_write(64'h1C0, 13'h1005, -1);
        do_read(64'h1C0, 13'h0042);
        wait_drain();

        // Back-pressure on beat 3
        bp_cnt = 0; bp_len = 5; bp_beat = 3;
        do_read(64'h1C0, 13'h0077);
        wait_drain();

        // Aliasing and offset: both addresses fall on line 1
        for (int k = 0; k < 8; k++) wdata[k] = {$urandom, $urandom};
        do_write(64'h4000_0040, 13'h1ABC, -1);
        do_read(64'h0000_007F, 13'h0123);
        wait_drain();

        // Write with stall between beats 2 and 3, then back-to-back reads
        for (int k = 0; k < 8; k++) wdata[k] = {$urandom, $urandom};
        do_write(64'h0000_0A80, 13'h1001, 2);
        do_read(64'h0000_0A80, 13'h0311);
        do_read(64'hFFFF_0040, 13'h0FFF);
        wait_drain();

        // Randomized traffic with aliased read addresses
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 8; k++) wdata[k] = {$urandom, $urandom};
            do_write({$urandom, $urandom}, {1'b1, 12'($urandom)}, $urandom_range(0, 9));
            a = {$urandom, 18'd0, 8'(lines[$urandom_range(0, lines.size() - 1)]), 6'($urandom)};
            do_read(a, {1'b0, 12'($urandom)});
            if ($urandom_range(0, 1) == 1) wait_drain();
        end
        wait_drain();

        // Asynchronous reset in the middle of beat 4
        do_read(64'h1C0, 13'h0055);
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #2;
            if (bus_respcyc && mon_beat == 4) break;
        end
        checks++;
        if (!(bus_respcyc && mon_beat == 4)) begin
            errors++;
            $display("FAIL midread_reach: respcyc=%b beat=%0d", bus_respcyc, mon_beat);
        end
        reset = 1'b0;
        bus_respack = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        exp_q.delete();
        mon_beat = 0;
        first_pending = 0;
        bp_beat = -1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_read(64'h1C0, 13'h0066);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
